// File: rtl/rover_drive_pkg.sv
// Shared drive types for the rover H-bridge path: sequencer states and the
// bridge input patterns, ordered {in1, in2, in3, in4}.
package rover_drive_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } drive_state_t;

    localparam logic [3:0] FWD_PAT   = 4'b1001;
    localparam logic [3:0] REV_PAT   = 4'b0110;
    localparam logic [3:0] COAST_PAT = 4'b0000;

    // Only RUN drives the bridge; every other state coasts.
    function automatic logic [3:0] bridge_pattern(input drive_state_t st, input logic dir);
        if (st != RUN) return COAST_PAT;
        return dir ? REV_PAT : FWD_PAT;
    endfunction

endpackage

// File: rtl/hbridge_drive_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous sensor inputs; the reset value lets
// each instance come out of reset in its safe level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hbridge_drive_sequencer.sv
// Dual H-bridge drive sequencer: ramped PWM duty, dead-time coast on reversal,
// IPS track cut-off and a filtered, latched overcurrent trip.
module hbridge_drive_sequencer
    import rover_drive_pkg::*;
#(
    parameter int PWM_BITS    = 15,
    parameter int RAMP_STEP   = 1024,
    parameter int DEAD_CYCLES = 100000,
    parameter int OC_FILTER   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [PWM_BITS:0]   duty_target,
    input  logic                dir_rev,
    input  logic                ips_n,
    input  logic                oc_cmp,
    input  logic                oc_clear,
    output logic                ena,
    output logic                enb,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    output logic                in4,
    output logic                oc_fault,
    output logic [PWM_BITS:0]   duty_now,
    output drive_state_t        state_dbg
);

    localparam int DUTY_W = PWM_BITS + 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int FILT_W = $clog2(OC_FILTER + 1);

    localparam logic [DUTY_W-1:0] FULL      = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_TRIP = FILT_W'(OC_FILTER);

    logic                ips_s;
    logic                oc_s;
    logic                ips_ok;
    logic [PWM_BITS-1:0] cnt;
    logic                wrap;
    logic                pwm_on;
    logic [DUTY_W-1:0]   eff_target;
    logic [DUTY_W-1:0]   ramp_diff;
    logic [DUTY_W-1:0]   ramp_delta;
    logic [DUTY_W-1:0]   duty_next;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                dead_dir;
    logic                dead_restart;
    logic                dead_expire;
    logic [FILT_W-1:0]   filter;
    logic [FILT_W-1:0]   filter_next;
    logic                trip;
    logic                dir_q;
    logic [3:0]          in_q;
    drive_state_t        state;
    drive_state_t        next_state;

    // IPS syncs to "no track" during reset so the drive never starts blind.
    sync2 #(.RST_VAL(1'b1)) u_sync_ips (
        .clk (clk),
        .rst (rst),
        .d   (ips_n),
        .q   (ips_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_oc (
        .clk (clk),
        .rst (rst),
        .d   (oc_cmp),
        .q   (oc_s)
    );

    assign ips_ok = ~ips_s;
    assign wrap   = &cnt;
    assign pwm_on = ({1'b0, cnt} < duty_now);

    always_comb begin
        eff_target = '0;
        if (run && ips_ok) begin
            eff_target = (duty_target > FULL) ? FULL : duty_target;
        end
        ramp_diff  = (eff_target > duty_now) ? (eff_target - duty_now) : (duty_now - eff_target);
        ramp_delta = (ramp_diff > STEP) ? STEP : ramp_diff;
    end

    // Trip on the sample that completes OC_FILTER consecutive highs.
    always_comb begin
        filter_next = '0;
        if (oc_s) begin
            filter_next = (filter == FILT_TRIP) ? filter : filter + FILT_W'(1);
        end
        trip = (filter_next == FILT_TRIP);
    end

    assign dead_restart = (dir_rev != dead_dir);
    assign dead_expire  = (state == DEAD) && !dead_restart && (dead_cnt == DEAD_LAST);

    always_comb begin
        next_state = state;
        duty_next  = duty_now;
        case (state)
            STOP: begin
                duty_next = '0;
                if (dir_rev != dir_q) begin
                    next_state = DEAD;
                end else if (run && ips_ok) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (dir_rev != dir_q) begin
                    next_state = DEAD;
                    duty_next  = '0;
                end else if (!ips_ok) begin
                    next_state = STOP;
                    duty_next  = '0;
                end else if (wrap) begin
                    if (duty_now == '0 && eff_target == '0) begin
                        next_state = STOP;
                    end else if (eff_target > duty_now) begin
                        duty_next = duty_now + ramp_delta;
                    end else begin
                        duty_next = duty_now - ramp_delta;
                    end
                end
            end
            DEAD: begin
                duty_next = '0;
                if (dead_expire) next_state = STOP;
            end
            FAULT: begin
                duty_next = '0;
                if (oc_clear && !oc_s) next_state = STOP;
            end
            default: begin
                next_state = STOP;
                duty_next  = '0;
            end
        endcase
        if (trip) begin
            next_state = FAULT;
            duty_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STOP;
            dir_q    <= 1'b0;
            duty_now <= '0;
            cnt      <= '0;
            filter   <= '0;
            dead_cnt <= '0;
            dead_dir <= 1'b0;
        end else begin
            state    <= next_state;
            duty_now <= duty_next;
            cnt      <= cnt + PWM_BITS'(1);
            filter   <= filter_next;
            if (next_state == DEAD && (state != DEAD || dead_restart)) begin
                dead_cnt <= '0;
                dead_dir <= dir_rev;
            end else if (state == DEAD) begin
                dead_cnt <= dead_cnt + DEAD_W'(1);
            end
            if (dead_expire && !trip) begin
                dir_q <= dir_rev;
            end
        end
    end

    // Outputs follow next_state, so enables drop on the same edge the bridge
    // pattern goes to coast and rise only once RUN owns the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena  <= 1'b0;
            enb  <= 1'b0;
            in_q <= COAST_PAT;
        end else begin
            ena  <= (next_state == RUN) && pwm_on;
            enb  <= (next_state == RUN) && pwm_on;
            in_q <= bridge_pattern(next_state, dir_q);
        end
    end

    assign {in1, in2, in3, in4} = in_q;
    assign oc_fault  = (state == FAULT);
    assign state_dbg = state;

endmodule
